// File: rtl/display_ctrl_pkg.sv
// Shared widths, constants and FSM encoding for the display sequencer.
// Also holds the input saturation helper used at conversion load time.
package display_ctrl_pkg;

   localparam int VAL_W     = 14;
   localparam int BCD_W     = 16;
   localparam int SHIFT_CYC = VAL_W;

   localparam logic [3:0]       DIG_BLANK = 4'hF;
   localparam logic [VAL_W-1:0] MAX_VAL   = 14'd9999;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   function automatic logic [VAL_W-1:0] sat_val(input logic [VAL_W-1:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

endpackage

// File: rtl/display_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one start cycle, then one shift per bit.
// done is high during the final shift cycle, so bcd is valid from the following cycle.
module bin2bcd_seq
   import display_ctrl_pkg::*;
(
   input  logic             CLK,
   input  logic             rst,
   input  logic             start,
   input  logic [VAL_W-1:0] bin,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   logic [BCD_W-1:0] acc_reg;
   logic [VAL_W-1:0] sr_reg;
   logic [3:0]       cnt_reg;
   logic             run_reg;
   logic [BCD_W-1:0] acc_adj;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_W/4; gi++) begin : g_adj
         assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                     acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
      end
   endgenerate

   assign done = run_reg && (cnt_reg == 4'(SHIFT_CYC-1));
   assign bcd  = acc_reg;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         acc_reg <= '0;
         sr_reg  <= '0;
         cnt_reg <= '0;
         run_reg <= 1'b0;
      end else if (start) begin
         acc_reg <= '0;
         sr_reg  <= sat_val(bin);
         cnt_reg <= '0;
         run_reg <= 1'b1;
      end else if (run_reg) begin
         {acc_reg, sr_reg} <= {acc_adj, sr_reg} << 1;
         cnt_reg           <= cnt_reg + 4'd1;
         if (done)
            run_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/display_ctrl.sv
// Display sequencer: arbitrates balance vs timed message, converts to BCD, blanks leading
// zeros, applies blink and generates the scanner clock.
module display_ctrl
   import display_ctrl_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int HOLD_CYC  = 5000,
   parameter int BLINK_DIV = 2500
)(
   input  logic             CLK,
   input  logic             rst,
   input  logic [VAL_W-1:0] bal_val,
   input  logic             bal_upd,
   input  logic [VAL_W-1:0] msg_val,
   input  logic             msg_req,
   output logic             msg_ack,
   input  logic             blink_en,
   output logic [3:0]       D3,
   output logic [3:0]       D2,
   output logic [3:0]       D1,
   output logic [3:0]       D0,
   output logic             scan_clk,
   output logic             busy,
   output logic             src_msg
);

   localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
   localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);

   state_t             state_reg;
   logic [VAL_W-1:0]   val_reg;
   logic               pend_reg;
   logic               hold_reg;
   logic [HOLD_W-1:0]  hold_cnt_reg;
   logic               busy_reg;
   logic               ack_reg;
   logic [BCD_W-1:0]   dig_reg;

   logic [SCAN_W-1:0]  scan_cnt_reg;
   logic               scan_clk_reg;
   logic [BLINK_W-1:0] blink_cnt_reg;
   logic               blink_off_reg;

   logic               conv_start;
   logic               conv_done;
   logic [BCD_W-1:0]   conv_bcd;
   logic [BCD_W-1:0]   dig_blanked;
   logic [4:1]         lead_zero;

   logic               grant_msg;
   logic               take_bal;
   logic               hold_expire;

   assign grant_msg   = (state_reg == ST_IDLE) && msg_req;
   assign take_bal    = (state_reg == ST_IDLE) && !msg_req && pend_reg && !hold_reg;
   assign hold_expire = hold_reg && (hold_cnt_reg == HOLD_W'(HOLD_CYC-1));
   assign conv_start  = (state_reg == ST_LOAD);

   bin2bcd_seq u_bcd (
      .CLK   (CLK),
      .rst   (rst),
      .start (conv_start),
      .bin   (val_reg),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // A digit is blanked while it and every more significant digit are zero; units never blank.
   assign lead_zero[4] = 1'b1;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            assign dig_blanked[3:0] = conv_bcd[3:0];
         end else begin : g_upper
            assign lead_zero[gi] = lead_zero[gi+1] && (conv_bcd[gi*4 +: 4] == 4'd0);
            assign dig_blanked[gi*4 +: 4] = lead_zero[gi] ? DIG_BLANK : conv_bcd[gi*4 +: 4];
         end
      end
   endgenerate

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         val_reg      <= '0;
         pend_reg     <= 1'b1;
         hold_reg     <= 1'b0;
         hold_cnt_reg <= '0;
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         dig_reg      <= {4{DIG_BLANK}};
      end else begin
         ack_reg <= 1'b0;

         // New update requests win over the clear so no change is ever lost.
         if (bal_upd || hold_expire)
            pend_reg <= 1'b1;
         else if (take_bal)
            pend_reg <= 1'b0;

         if (grant_msg) begin
            hold_reg     <= 1'b1;
            hold_cnt_reg <= '0;
         end else if (hold_expire) begin
            hold_reg <= 1'b0;
         end else if (hold_reg) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
         end

         case (state_reg)
            ST_IDLE: begin
               if (grant_msg) begin
                  ack_reg   <= 1'b1;
                  val_reg   <= msg_val;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_LOAD;
               end else if (take_bal) begin
                  val_reg   <= bal_val;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_LOAD;
               end
            end
            ST_LOAD: state_reg <= ST_SHIFT;
            ST_SHIFT: begin
               if (conv_done) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               dig_reg   <= dig_blanked;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         scan_cnt_reg  <= '0;
         scan_clk_reg  <= 1'b0;
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
      end else begin
         if (scan_cnt_reg == SCAN_W'(SCAN_DIV-1)) begin
            scan_cnt_reg <= '0;
            scan_clk_reg <= ~scan_clk_reg;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end

         if (blink_cnt_reg == BLINK_W'(BLINK_DIV-1)) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= ~blink_off_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   // Blink only masks the outputs; the committed digits stay intact underneath.
   assign {D3, D2, D1, D0} = (blink_en && blink_off_reg) ? {4{DIG_BLANK}} : dig_reg;
   assign scan_clk = scan_clk_reg;
   assign busy     = busy_reg;
   assign msg_ack  = ack_reg;
   assign src_msg  = hold_reg;

endmodule

// File: tb/tb_display_ctrl.sv
// Self-checking bench for display_ctrl: directed steps with random values, checked against a
// decimal-arithmetic model of the displayed digits.
module tb_display_ctrl;

   localparam int SCAN_DIV  = 1000;
   localparam int HOLD_CYC  = 5000;
   localparam int BLINK_DIV = 2500;

   logic        CLK = 1'b0;
   logic        rst;
   logic [13:0] bal_val;
   logic        bal_upd;
   logic [13:0] msg_val;
   logic        msg_req;
   logic        msg_ack;
   logic        blink_en;
   logic [3:0]  D3, D2, D1, D0;
   logic        scan_clk;
   logic        busy;
   logic        src_msg;
   logic [15:0] d_all;

   int checks = 0;
   int errors = 0;

   display_ctrl #(
      .SCAN_DIV  (SCAN_DIV),
      .HOLD_CYC  (HOLD_CYC),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .CLK      (CLK),
      .rst      (rst),
      .bal_val  (bal_val),
      .bal_upd  (bal_upd),
      .msg_val  (msg_val),
      .msg_req  (msg_req),
      .msg_ack  (msg_ack),
      .blink_en (blink_en),
      .D3       (D3),
      .D2       (D2),
      .D1       (D1),
      .D0       (D0),
      .scan_clk (scan_clk),
      .busy     (busy),
      .src_msg  (src_msg)
   );

   always #5 CLK = ~CLK;
   assign d_all = {D3, D2, D1, D0};

   // Expected display: saturate, split into decimal digits, blank by magnitude.
   function automatic logic [15:0] model_digits(input int v);
      int s;
      logic [15:0] r;
      s = (v > 9999) ? 9999 : v;
      r = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
      if (s < 1000) r[15:12] = 4'hF;
      if (s < 100)  r[11:8]  = 4'hF;
      if (s < 10)   r[7:4]   = 4'hF;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic convert_bal(input int v);
      logic [15:0] exp;
      exp = model_digits(v);
      @(negedge CLK);
      bal_val = 14'(v);
      bal_upd = 1'b1;
      @(negedge CLK);
      bal_upd = 1'b0;
      repeat (20) @(negedge CLK);
      $display("bal %0d -> D=%h expected %h", v, d_all, exp);
      check("bal_busy_done", 32'(busy), 32'd0);
      check("bal_digits", 32'(d_all), 32'(exp));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_d, busy_n, rises, off_len, on_len, hi_len, lo_len, b, v1, v2, v3;
      logic prev, found;

      rst = 1'b1; bal_val = '0; bal_upd = 1'b0; msg_val = '0; msg_req = 1'b0; blink_en = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_D", 32'(d_all), 32'hFFFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(msg_ack), 32'd0);
      check("rst_src", 32'(src_msg), 32'd0);
      check("rst_scan", 32'(scan_clk), 32'd0);

      // Forced balance conversion after reset: latch on the first edge, digits 16 edges later,
      // i.e. visible at the 17th negedge after release.
      rst = 1'b0;
      first_d = 0; busy_n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK);
         if (busy) busy_n++;
         if (first_d == 0 && d_all == model_digits(0)) first_d = i;
      end
      $display("reset conversion: busy %0d cycles, D=%h at negedge %0d", busy_n, d_all, first_d);
      check("t1_busy_len", 32'(busy_n), 32'd15);
      check("t1_latency", 32'(first_d), 32'd17);
      check("t1_D", 32'(d_all), 32'(model_digits(0)));

      convert_bal(1234);
      convert_bal(12000);
      convert_bal(50);
      convert_bal(1005);
      convert_bal(9999);
      convert_bal(10000);
      convert_bal(7);
      for (int k = 0; k < 6; k++) convert_bal(int'($urandom_range(16383, 0)));

      // Message wins over a simultaneous balance update and holds for HOLD_CYC cycles.
      b = int'($urandom_range(9999, 0));
      @(negedge CLK);
      msg_val = 14'd25; msg_req = 1'b1; bal_val = 14'(b); bal_upd = 1'b1;
      @(negedge CLK);
      $display("msg 25 request: ack=%0b src_msg=%0b", msg_ack, src_msg);
      check("msg_ack_pulse", 32'(msg_ack), 32'd1);
      check("msg_src_set", 32'(src_msg), 32'd1);
      msg_req = 1'b0; bal_upd = 1'b0;
      @(negedge CLK);
      check("msg_ack_single", 32'(msg_ack), 32'd0);
      repeat (20) @(negedge CLK);
      check("msg_digits", 32'(d_all), 32'(model_digits(25)));
      repeat (HOLD_CYC - 22) @(negedge CLK);
      check("msg_hold_src", 32'(src_msg), 32'd1);
      check("msg_hold_D", 32'(d_all), 32'(model_digits(25)));
      @(negedge CLK);
      check("msg_expire_src", 32'(src_msg), 32'd0);
      repeat (20) @(negedge CLK);
      $display("msg expired: balance %0d -> D=%h", b, d_all);
      check("msg_bal_back", 32'(d_all), 32'(model_digits(b)));

      // Two updates during one conversion merge into exactly one more conversion.
      v1 = int'($urandom_range(16383, 0));
      v2 = int'($urandom_range(16383, 0));
      v3 = int'($urandom_range(16383, 0));
      @(negedge CLK);
      bal_val = 14'(v1); bal_upd = 1'b1;
      @(negedge CLK);
      bal_upd = 1'b0;
      rises = 0; prev = busy;
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         if (busy && !prev) rises++;
         prev = busy;
         if (i == 4)      begin bal_val = 14'(v2); bal_upd = 1'b1; end
         else if (i == 5) bal_upd = 1'b0;
         else if (i == 7) begin bal_val = 14'(v3); bal_upd = 1'b1; end
         else if (i == 8) bal_upd = 1'b0;
      end
      $display("merged updates %0d/%0d/%0d: %0d conversions, D=%h", v1, v2, v3, rises, d_all);
      check("merge_conv_count", 32'(rises), 32'd2);
      check("merge_digits", 32'(d_all), 32'(model_digits(v3)));

      // Blink: equal off/on halves, digits preserved, immediate restore on disable.
      convert_bal(1234);
      blink_en = 1'b1;
      found = 1'b0; prev = (d_all == 16'hFFFF);
      for (int i = 0; i < 2*BLINK_DIV + 10 && !found; i++) begin
         @(negedge CLK);
         if (d_all == 16'hFFFF && !prev) found = 1'b1;
         prev = (d_all == 16'hFFFF);
      end
      check("blink_sync", 32'(found), 32'd1);
      off_len = 0;
      while (d_all == 16'hFFFF && off_len < 3*BLINK_DIV) begin off_len++; @(negedge CLK); end
      check("blink_on_digits", 32'(d_all), 32'(model_digits(1234)));
      on_len = 0;
      while (d_all != 16'hFFFF && on_len < 3*BLINK_DIV) begin on_len++; @(negedge CLK); end
      $display("blink: off %0d cycles, on %0d cycles", off_len, on_len);
      check("blink_off_len", 32'(off_len), 32'(BLINK_DIV));
      check("blink_on_len", 32'(on_len), 32'(BLINK_DIV));
      blink_en = 1'b0;
      #1;
      check("blink_disable", 32'(d_all), 32'(model_digits(1234)));

      // scan_clk: high for SCAN_DIV cycles, period 2*SCAN_DIV.
      found = 1'b0; prev = scan_clk;
      for (int i = 0; i < 2*SCAN_DIV + 10 && !found; i++) begin
         @(negedge CLK);
         if (scan_clk && !prev) found = 1'b1;
         prev = scan_clk;
      end
      check("scan_sync", 32'(found), 32'd1);
      hi_len = 0;
      while (scan_clk && hi_len < 3*SCAN_DIV) begin hi_len++; @(negedge CLK); end
      lo_len = 0;
      while (!scan_clk && lo_len < 3*SCAN_DIV) begin lo_len++; @(negedge CLK); end
      $display("scan_clk: high %0d, period %0d", hi_len, hi_len + lo_len);
      check("scan_high", 32'(hi_len), 32'(SCAN_DIV));
      check("scan_period", 32'(hi_len + lo_len), 32'(2*SCAN_DIV));

      // Reset in the middle of a conversion.
      @(negedge CLK);
      bal_val = 14'd4321; bal_upd = 1'b1;
      @(negedge CLK);
      bal_upd = 1'b0;
      repeat (5) @(negedge CLK);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      $display("reset mid-shift: D=%h busy=%0b", d_all, busy);
      check("midrst_D", 32'(d_all), 32'hFFFF);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_src", 32'(src_msg), 32'd0);
      check("midrst_scan", 32'(scan_clk), 32'd0);
      @(negedge CLK);
      rst = 1'b0;
      repeat (20) @(negedge CLK);
      check("postrst_digits", 32'(d_all), 32'(model_digits(4321)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
